// File: rtl/neuron_stream_mac_if.sv
// Stream interface for neuron_stream_mac.
// Carries the input beat handshake (LANES samples per beat) and the 8-bit
// activation result handshake. The slave modport is the neuron itself;
// the master modport is the surrounding producer/consumer.
interface neuron_stream_mac_if #(
    parameter int LANES  = 7,
    parameter int DATA_W = 16
);
    logic [LANES-1:0][DATA_W-1:0] in_data;
    logic                         in_valid;
    logic                         in_ready;
    logic [7:0]                   out_data;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/neuron_stream_mac.sv
// neuron_stream_mac: streamed multiply-accumulate neuron.
// Takes a NUM_INPUTS-sample vector LANES samples per beat, multiplies each
// lane by its compile-time weight, accumulates, adds the bias, clamps to a
// signed 16-bit range and maps the result through a 4096-entry sigmoid LUT.
// Optional feature macro: NEURON_SAT_FLAG_EN adds the sat_flag output,
// which reports that the clamp was active for the presented result.
module neuron_stream_mac #(
    parameter int NUM_INPUTS = 49,
    parameter int LANES      = 7,
    parameter int DATA_W     = 16,
    parameter int WEIGHT_W   = 16,
    parameter int ACC_W      = 48,
    parameter logic signed [WEIGHT_W-1:0] WEIGHTS [NUM_INPUTS+1] = '{default: '0},
    parameter int LUT_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    neuron_stream_mac_if.slave bus,
    output logic               busy
`ifdef NEURON_SAT_FLAG_EN
    ,
    output logic               sat_flag
`endif
);

    localparam int BEATS  = (NUM_INPUTS + LANES - 1) / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int LAT_W  = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;

    localparam logic signed [WEIGHT_W-1:0] BIAS    = WEIGHTS[NUM_INPUTS];
    localparam logic signed [ACC_W:0]      SAT_MAX = (ACC_W+1)'(32767);
    localparam logic signed [ACC_W:0]      SAT_MIN = -(ACC_W+1)'(32768);

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, SAT, LUT, DONE} state_t;

    state_t                    state_reg;
    logic                      in_ready_reg;
    logic                      out_valid_reg;
    logic [7:0]                out_data_reg;
    logic [CNT_W-1:0]          beat_cnt_reg;
    logic                      drain_cnt_reg;
    logic [LAT_W-1:0]          lat_cnt_reg;
    logic [11:0]               addr_reg;
`ifdef NEURON_SAT_FLAG_EN
    logic                      sat_flag_reg;
`endif

    logic                      s1_valid_reg;
    logic                      s1_first_reg;
    logic signed [ACC_W-1:0]   s1_sum_reg;
    logic signed [ACC_W-1:0]   acc_reg;

    logic [LANES-1:0][WEIGHT_W-1:0] lane_w;
    logic [LANES-1:0][PROD_W-1:0]   lane_prod;
    logic signed [ACC_W-1:0]        beat_sum;
    logic                           beat_fire;
    logic                           last_beat;

    logic signed [ACC_W:0]     sum_ext;
    logic                      sat_hi;
    logic                      sat_lo;
    logic signed [15:0]        clamped;
    logic [11:0]               addr_next;

    logic [7:0]                lut_rom [4096];
    logic [7:0]                lut_q;

    assign beat_fire = bus.in_valid && in_ready_reg;
    assign last_beat = (beat_cnt_reg == CNT_W'(BEATS - 1));

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign busy          = (state_reg != IDLE);
`ifdef NEURON_SAT_FLAG_EN
    assign sat_flag      = sat_flag_reg;
`endif

    // Weight for a flat input index; padding positions past the vector end weigh 0.
    function automatic logic [WEIGHT_W-1:0] weight_at(input int idx);
        if (idx < NUM_INPUTS) begin
            return WEIGHTS[idx];
        end
        return '0;
    endfunction

    // Select each lane's weight for the beat currently being offered.
    always_comb begin
        lane_w = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_cnt_reg == CNT_W'(b)) begin
                    lane_w[l] = weight_at(b * LANES + l);
                end
            end
        end
    end

    // Full-precision signed product per lane.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_prod[gi] = PROD_W'($signed(bus.in_data[gi])) *
                                   PROD_W'($signed(lane_w[gi]));
        end
    endgenerate

    // Adder tree over the lane products, widened to the accumulator width.
    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + ACC_W'($signed(lane_prod[l]));
        end
    end

    // Stage 1: register the beat sum and whether it opens a new vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_first_reg <= 1'b0;
            s1_sum_reg   <= '0;
        end else begin
            s1_valid_reg <= beat_fire;
            s1_first_reg <= (beat_cnt_reg == '0);
            if (beat_fire) begin
                s1_sum_reg <= beat_sum;
            end
        end
    end

    // Stage 2: the first beat of a vector loads acc, later beats add to it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (s1_valid_reg) begin
            acc_reg <= s1_first_reg ? s1_sum_reg : acc_reg + s1_sum_reg;
        end
    end

    // Bias add, clamp to signed 16 bits, and offset-binary LUT address.
    always_comb begin
        sum_ext   = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(BIAS);
        sat_hi    = (sum_ext > SAT_MAX);
        sat_lo    = (sum_ext < SAT_MIN);
        clamped   = sat_hi ? 16'sh7FFF : (sat_lo ? 16'sh8000 : sum_ext[15:0]);
        addr_next = 12'({~clamped[15], clamped[14:0]} >> 4);
    end

    // Behavioural stand-in for the sigmoid LUT IP: a monotonic ramp (addr/16).
    generate
        for (gi = 0; gi < 4096; gi++) begin : g_rom
            assign lut_rom[gi] = 8'(gi >> 4);
        end
    endgenerate

    // LUT read path: LUT_LATENCY-1 registers here, out_data is the final capture.
    generate
        if (LUT_LATENCY == 1) begin : g_lut_comb
            assign lut_q = lut_rom[addr_reg];
        end else begin : g_lut_reg
            logic [7:0] pipe_reg [LUT_LATENCY-1];
            // Registered ROM read followed by any extra delay stages.
            always_ff @(posedge clk) begin
                pipe_reg[0] <= lut_rom[addr_reg];
                for (int i = 1; i < LUT_LATENCY - 1; i++) begin
                    pipe_reg[i] <= pipe_reg[i-1];
                end
            end
            assign lut_q = pipe_reg[LUT_LATENCY-2];
        end
    endgenerate

    // Control FSM: beat acceptance, pipeline drain, clamp, LUT wait, result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            beat_cnt_reg  <= '0;
            drain_cnt_reg <= 1'b0;
            lat_cnt_reg   <= '0;
            addr_reg      <= '0;
`ifdef NEURON_SAT_FLAG_EN
            sat_flag_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (state_reg == IDLE) begin
                        in_ready_reg <= 1'b1;
                    end
                    if (beat_fire) begin
                        if (last_beat) begin
                            state_reg    <= DRAIN;
                            in_ready_reg <= 1'b0;
                            beat_cnt_reg <= '0;
                        end else begin
                            state_reg    <= ACCUM;
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles: last beat through stage 1, then into acc.
                    if (drain_cnt_reg) begin
                        drain_cnt_reg <= 1'b0;
                        state_reg     <= SAT;
                    end else begin
                        drain_cnt_reg <= 1'b1;
                    end
                end
                SAT: begin
                    addr_reg    <= addr_next;
                    lat_cnt_reg <= '0;
                    state_reg   <= LUT;
`ifdef NEURON_SAT_FLAG_EN
                    sat_flag_reg <= sat_hi | sat_lo;
`endif
                end
                LUT: begin
                    if (lat_cnt_reg == LAT_W'(LUT_LATENCY - 1)) begin
                        out_data_reg  <= lut_q;
                        out_valid_reg <= 1'b1;
                        lat_cnt_reg   <= '0;
                        state_reg     <= DONE;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
`ifdef NEURON_SAT_FLAG_EN
                        sat_flag_reg  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
